// File: rtl/keypad_operand_entry.sv
// Keypad operand entry controller: captures two BCD operands and an operator
// from a synchronised keypad stream and launches the arithmetic unit.
module keypad_operand_entry #(
  parameter int N_DIGITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  calc_ready,
  input  logic                  calc_done,
  output logic [4*N_DIGITS-1:0] operand_a,
  output logic [4*N_DIGITS-1:0] operand_b,
  output logic [3:0]            a_count,
  output logic [3:0]            b_count,
  output logic [1:0]            op_sel,
  output logic                  start,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  key_err,
  output logic [2:0]            state_o
);

  localparam int W = 4 * N_DIGITS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER_A = 3'd1,
    S_ENTER_B = 3'd2,
    S_LAUNCH  = 3'd3,
    S_BUSY    = 3'd4,
    S_RESULT  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic [W-1:0]           operand_a_q, operand_a_d;
  logic [W-1:0]           operand_b_q, operand_b_d;
  logic [3:0]             a_count_q, a_count_d;
  logic [3:0]             b_count_q, b_count_d;
  logic [1:0]             op_sel_q, op_sel_d;
  logic                   key_err_q, key_err_d;

  logic                   key_event;
  logic                   key_is_digit;
  logic                   key_is_op;
  logic                   key_is_eq;
  logic                   key_is_clr;
  logic [1:0]             op_code;
  logic [W-1:0]           digit_ext;
  logic                   a_full;
  logic                   b_full;

  // key_valid synchroniser and rising-edge detector: one event per press.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], key_valid};
    sync_prev_d = sync_q[SYNC_STAGES-1];
    key_event   = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  end

  // Operator keys A..D map to 00..11 by subtracting 2 from the low bits.
  always_comb begin
    key_is_digit = (key_code <= 4'd9);
    key_is_op    = (key_code >= 4'hA) && (key_code <= 4'hD);
    key_is_eq    = (key_code == 4'hE);
    key_is_clr   = (key_code == 4'hF);
    op_code      = key_code[1:0] - 2'd2;
    digit_ext    = W'(key_code);
    a_full       = (a_count_q == 4'(N_DIGITS));
    b_full       = (b_count_q == 4'(N_DIGITS));
  end

  // Handshake: start is high for every cycle spent in LAUNCH; the launch is
  // taken on the first cycle where start and calc_ready are both high.
  always_comb begin
    state_d     = state_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    a_count_d   = a_count_q;
    b_count_d   = b_count_q;
    op_sel_d    = op_sel_q;
    key_err_d   = 1'b0;

    unique case (state_q)
      S_LAUNCH: if (calc_ready) state_d = S_BUSY;
      S_BUSY:   if (calc_done)  state_d = S_RESULT;
      S_IDLE, S_ENTER_A, S_ENTER_B, S_RESULT: ;
      default:  state_d = S_IDLE;
    endcase

    if (key_event) begin
      if (state_q == S_LAUNCH || state_q == S_BUSY) begin
        key_err_d = 1'b1;
      end else if (key_is_clr) begin
        operand_a_d = '0;
        operand_b_d = '0;
        a_count_d   = 4'd0;
        b_count_d   = 4'd0;
        op_sel_d    = 2'd0;
        state_d     = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (key_is_digit) begin
              operand_a_d = digit_ext;
              a_count_d   = 4'd1;
              state_d     = S_ENTER_A;
            end else begin
              key_err_d = 1'b1;
            end
          end
          S_ENTER_A: begin
            if (key_is_digit) begin
              if (a_full) begin
                key_err_d = 1'b1;
              end else begin
                operand_a_d = (operand_a_q << 4) | digit_ext;
                a_count_d   = a_count_q + 4'd1;
              end
            end else if (key_is_op) begin
              op_sel_d = op_code;
              state_d  = S_ENTER_B;
            end else begin
              key_err_d = 1'b1;
            end
          end
          S_ENTER_B: begin
            if (key_is_digit) begin
              if (b_full) begin
                key_err_d = 1'b1;
              end else begin
                operand_b_d = (operand_b_q << 4) | digit_ext;
                b_count_d   = b_count_q + 4'd1;
              end
            end else if (key_is_op) begin
              // The operator may be changed only until B's first digit.
              if (b_count_q == 4'd0) op_sel_d = op_code;
              else                   key_err_d = 1'b1;
            end else if (key_is_eq) begin
              if (b_count_q != 4'd0) state_d = S_LAUNCH;
              else                   key_err_d = 1'b1;
            end else begin
              key_err_d = 1'b1;
            end
          end
          S_RESULT: begin
            if (key_is_digit) begin
              operand_a_d = digit_ext;
              operand_b_d = '0;
              a_count_d   = 4'd1;
              b_count_d   = 4'd0;
              state_d     = S_ENTER_A;
            end else begin
              key_err_d = 1'b1;
            end
          end
          default: key_err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      a_count_q   <= 4'd0;
      b_count_q   <= 4'd0;
      op_sel_q    <= 2'd0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      a_count_q   <= a_count_d;
      b_count_q   <= b_count_d;
      op_sel_q    <= op_sel_d;
      key_err_q   <= key_err_d;
    end
  end

  assign operand_a    = operand_a_q;
  assign operand_b    = operand_b_q;
  assign a_count      = a_count_q;
  assign b_count      = b_count_q;
  assign op_sel       = op_sel_q;
  assign key_err      = key_err_q;
  assign start        = (state_q == S_LAUNCH);
  assign busy         = (state_q == S_LAUNCH) || (state_q == S_BUSY);
  assign result_valid = (state_q == S_RESULT);
  assign state_o      = state_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: digit-queue reference model compared every
// cycle, plus directed literal expectations from the test plan.
module tb_keypad_operand_entry;

  localparam int N_DIGITS    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int W           = 4 * N_DIGITS;
  localparam int GAP         = 4;

  localparam int M_IDLE   = 0;
  localparam int M_A      = 1;
  localparam int M_B      = 2;
  localparam int M_LAUNCH = 3;
  localparam int M_BUSY   = 4;
  localparam int M_RESULT = 5;

  // Clock and reset.
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'd0;
  logic         calc_ready = 1'b1;
  logic         calc_done = 1'b0;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [3:0]   a_count;
  logic [3:0]   b_count;
  logic [1:0]   op_sel;
  logic         start;
  logic         busy;
  logic         result_valid;
  logic         key_err;
  logic [2:0]   state_o;

  always #5 clk = ~clk;

  keypad_operand_entry #(
    .N_DIGITS   (N_DIGITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .calc_ready  (calc_ready),
    .calc_done   (calc_done),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .a_count     (a_count),
    .b_count     (b_count),
    .op_sel      (op_sel),
    .start       (start),
    .busy        (busy),
    .result_valid(result_valid),
    .key_err     (key_err),
    .state_o     (state_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0;
  int start_cycles = 0;

  // Reference model: operands kept as digit queues, keys scheduled by edge.
  int         m_state;
  int         m_next;
  int         m_op;
  bit         m_err;
  int         a_dig[$];
  int         b_dig[$];
  logic [3:0] key_q[$];
  int         key_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack_a();
    logic [W-1:0] v;
    v = '0;
    foreach (a_dig[i]) v = (v << 4) | W'(a_dig[i]);
    return v;
  endfunction

  function automatic logic [W-1:0] pack_b();
    logic [W-1:0] v;
    v = '0;
    foreach (b_dig[i]) v = (v << 4) | W'(b_dig[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_next  = M_IDLE;
    m_op    = 0;
    m_err   = 1'b0;
    a_dig.delete();
    b_dig.delete();
    key_q.delete();
    key_cyc_q.delete();
  endtask

  task automatic model_key(input int code);
    bit digit;
    bit op;
    bit eq;
    digit = (code < 10);
    op    = (code >= 10) && (code <= 13);
    eq    = (code == 14);
    if (m_state == M_LAUNCH || m_state == M_BUSY) begin
      m_err = 1'b1;
      return;
    end
    if (code == 15) begin
      a_dig.delete();
      b_dig.delete();
      m_op   = 0;
      m_next = M_IDLE;
      return;
    end
    case (m_state)
      M_IDLE, M_RESULT: begin
        if (digit) begin
          a_dig.delete();
          b_dig.delete();
          a_dig.push_back(code);
          m_next = M_A;
        end else m_err = 1'b1;
      end
      M_A: begin
        if (digit) begin
          if (a_dig.size() == N_DIGITS) m_err = 1'b1;
          else a_dig.push_back(code);
        end else if (op) begin
          m_op   = code - 10;
          m_next = M_B;
        end else m_err = 1'b1;
      end
      M_B: begin
        if (digit) begin
          if (b_dig.size() == N_DIGITS) m_err = 1'b1;
          else b_dig.push_back(code);
        end else if (op) begin
          if (b_dig.size() == 0) m_op = code - 10;
          else m_err = 1'b1;
        end else if (eq && b_dig.size() > 0) m_next = M_LAUNCH;
        else m_err = 1'b1;
      end
      default: m_err = 1'b1;
    endcase
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_next = m_state;
      m_err  = 1'b0;
      if (m_state == M_LAUNCH && calc_ready) m_next = M_BUSY;
      if (m_state == M_BUSY && calc_done) m_next = M_RESULT;
      while (key_cyc_q.size() > 0 && key_cyc_q[0] < cyc) begin
        void'(key_q.pop_front());
        void'(key_cyc_q.pop_front());
      end
      if (key_cyc_q.size() > 0 && key_cyc_q[0] == cyc) begin
        model_key(int'(key_q.pop_front()));
        void'(key_cyc_q.pop_front());
      end
      m_state = m_next;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (key_err) err_seen++;
    if (start) start_cycles++;
    chk("state_o", state_o, m_state);
    chk("operand_a", operand_a, pack_a());
    chk("operand_b", operand_b, pack_b());
    chk("a_count", a_count, a_dig.size());
    chk("b_count", b_count, b_dig.size());
    chk("op_sel", op_sel, m_op);
    chk("start", start, m_state == M_LAUNCH);
    chk("busy", busy, m_state == M_LAUNCH || m_state == M_BUSY);
    chk("result_valid", result_valid, m_state == M_RESULT);
    chk("key_err", key_err, m_err);
  end

  // Driver tasks.
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic start_key(input logic [3:0] code);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code  = code;
    key_q.push_back(code);
    key_cyc_q.push_back(cyc + 1 + SYNC_STAGES);
  endtask

  task automatic end_key();
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic press_key(input logic [3:0] code);
    start_key(code);
    repeat (2) @(posedge clk);
    end_key();
  endtask

  task automatic pulse_done();
    @(posedge clk);
    #1;
    calc_done = 1'b1;
    @(posedge clk);
    #1;
    calc_done = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while (state_o !== target && n < budget) begin
      at_neg();
      n++;
    end
    chk("wait_state", state_o, target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int e0;
    model_reset();
    repeat (3) at_neg();
    chk("rst_state", state_o, 3'd0);
    chk("rst_operand_a", operand_a, 16'h0000);
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Illegal keys in IDLE, clear without error, calc_done ignored.
    e0 = err_seen;
    press_key(4'hA);
    press_key(4'hE);
    press_key(4'hF);
    pulse_done();
    at_neg();
    chk("idle_errs", err_seen - e0, 2);
    chk("idle_state", state_o, 3'd0);

    // 12 * 3 with immediate ready.
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'hA);
    press_key(4'd3);
    start_cycles = 0;
    press_key(4'hE);
    wait_state(3'd4, 20);
    chk("t1_operand_a", operand_a, 16'h0012);
    chk("t1_operand_b", operand_b, 16'h0003);
    chk("t1_op_sel", op_sel, 2'b00);
    chk("t1_start_cycles", start_cycles, 1);
    pulse_done();
    wait_state(3'd5, 20);
    chk("t1_result_valid", result_valid, 1'b1);
    chk("t1_keep_a", operand_a, 16'h0012);

    // Overflow on the fifth digit, starting from RESULT.
    e0 = err_seen;
    press_key(4'd9);
    press_key(4'd8);
    press_key(4'd7);
    press_key(4'd6);
    chk("t2_no_err_yet", err_seen - e0, 0);
    press_key(4'd5);
    at_neg();
    chk("t2_operand_a", operand_a, 16'h9876);
    chk("t2_a_count", a_count, 4'd4);
    chk("t2_err_on_5", err_seen - e0, 1);
    chk("t2_operand_b", operand_b, 16'h0000);

    // Long hold: one event, registered two edges after first sample.
    press_key(4'hF);
    start_key(4'd7);
    repeat (2) @(posedge clk);
    at_neg();
    chk("t3_before", operand_a, 16'h0000);
    @(posedge clk);
    at_neg();
    chk("t3_after", operand_a, 16'h0007);
    repeat (46) @(posedge clk);
    end_key();
    at_neg();
    chk("t3_single_a", operand_a, 16'h0007);
    chk("t3_single_cnt", a_count, 4'd1);

    // Operator replacement, then locked once B has a digit.
    press_key(4'hF);
    e0 = err_seen;
    press_key(4'd4);
    press_key(4'hB);
    press_key(4'hC);
    press_key(4'hE);
    press_key(4'd2);
    at_neg();
    chk("t4_op_sel", op_sel, 2'b10);
    chk("t4_eq_empty_b_err", err_seen - e0, 1);
    press_key(4'hC);
    at_neg();
    chk("t4_op_err", err_seen - e0, 2);
    chk("t4_op_kept", op_sel, 2'b10);

    // Launch held off by calc_ready; CLEAR rejected while busy.
    calc_ready = 1'b0;
    start_cycles = 0;
    press_key(4'hE);
    wait_state(3'd3, 20);
    repeat (10) at_neg();
    chk("t5_start_held", start, 1'b1);
    chk("t5_still_launch", state_o, 3'd3);
    calc_ready = 1'b1;
    wait_state(3'd4, 20);
    chk("t5_start_cycles", start_cycles >= 10, 1'b1);
    chk("t5_start_drop", start, 1'b0);
    e0 = err_seen;
    press_key(4'hF);
    at_neg();
    chk("t5_clr_err", err_seen - e0, 1);
    chk("t5_stay_busy", state_o, 3'd4);
    chk("t5_operand_a", operand_a, 16'h0004);
    pulse_done();
    wait_state(3'd5, 20);

    // Async reset while start is pending.
    press_key(4'hF);
    calc_ready = 1'b0;
    press_key(4'd1);
    press_key(4'hA);
    press_key(4'd2);
    press_key(4'hE);
    at_neg();
    chk("t6_start_pending", start, 1'b1);
    rst = 1'b0;
    #1;
    chk("t6_start_drop", start, 1'b0);
    chk("t6_busy_drop", busy, 1'b0);
    chk("t6_a_drop", operand_a, 16'h0000);
    chk("t6_b_drop", operand_b, 16'h0000);
    chk("t6_state_idle", state_o, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    calc_ready = 1'b1;
    press_key(4'd5);
    at_neg();
    chk("t6_state_a", state_o, 3'd1);
    chk("t6_operand_a", operand_a, 16'h0005);

    repeat (3) at_neg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_operand_entry.md
Name: keypad_operand_entry

Overview:
- Parametrised keypad-entry controller for the calculator front end, feeding the Booth multiplier datapath.
- Captures two multi-digit BCD operands and an operator from a 4-bit keypad stream, and launches the arithmetic unit with a start/ready handshake.
- Tracks multiplier completion.
- Adds over the previous-generation entry FSM: configurable digit count, input synchronisation, clear key, operator replacement, overflow/illegal-key error reporting, and return to a result state.

Parameters:
- N_DIGITS, 4: maximum BCD digits per operand (1..8).
- SYNC_STAGES, 2: synchroniser flops on key_valid (>=2).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- key_valid, input, 1: level, high while a key is held (asynchronous to clk).
- key_code, input, 4: 0-9 digit; A=MUL, B=ADD, C=SUB, D=DIV; E=EQUALS; F=CLEAR. Stable while key_valid is high.
- calc_ready, input, 1: arithmetic unit can accept start.
- calc_done, input, 1: one-cycle pulse, result valid.
- operand_a, output, 4*N_DIGITS: BCD operand A, right-aligned.
- operand_b, output, 4*N_DIGITS: BCD operand B, right-aligned.
- a_count, output, 4: digits entered in A.
- b_count, output, 4: digits entered in B.
- op_sel, output, 2: operator (00 MUL, 01 ADD, 10 SUB, 11 DIV).
- start, output, 1: launch request, held until handshake completes.
- busy, output, 1: operation in flight.
- result_valid, output, 1: high in RESULT.
- key_err, output, 1: one-cycle pulse on any rejected key.
- state_o, output, 3: current state encoding, for debug/display.

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser and edge register cleared.
- Key event:
  - key_valid passes through SYNC_STAGES flops; event = sync_out & ~sync_prev.
  - A key first sampled high at edge k updates registers at edge k+SYNC_STAGES.
  - key_code is sampled on that same edge.
  - A held key produces exactly one event; release generates nothing.
- Digit entry: operand <= {operand[4*N_DIGITS-5:0], digit}; count+1.
  - Digit when count == N_DIGITS: operand unchanged, key_err pulse.
- States (state_o: IDLE=0, ENTER_A=1, ENTER_B=2, LAUNCH=3, BUSY=4, RESULT=5):
  - IDLE:
    - digit -> load into A, ENTER_A.
    - operator/EQUALS -> key_err, stay.
    - CLEAR -> stay, no error.
  - ENTER_A:
    - digit -> append.
    - operator -> latch op_sel, ENTER_B.
    - EQUALS -> key_err.
  - ENTER_B:
    - digit -> append to B.
    - operator with b_count==0 -> replace op_sel.
    - operator with b_count>0 -> key_err.
    - EQUALS with b_count>=1 -> LAUNCH.
    - EQUALS with b_count==0 -> key_err.
  - LAUNCH:
    - start=1, busy=1.
    - Cycle with start&calc_ready -> BUSY; start drops next cycle.
    - All keys -> key_err.
  - BUSY:
    - busy=1; calc_done -> RESULT.
    - All keys -> key_err.
    - calc_done in any other state is ignored.
  - RESULT:
    - result_valid=1; operands and op_sel retained.
    - Digit -> clear A, B, counts; load digit into A; ENTER_A.
    - operator -> key_err.
- CLEAR in IDLE/ENTER_A/ENTER_B/RESULT: operands, counts, op_sel -> 0; state IDLE.
- CLEAR in LAUNCH/BUSY: key_err, no effect (no abort of in-flight operation).
- Async reset mid-operation: immediate return to reset values; pending start withdrawn.
- key_err never coincides with a register update from the same key.

Test Plan:
- N_DIGITS=4, SYNC_STAGES=2: keys 1,2,A,3,E; calc_ready=1 -> operand_a=16'h0012, operand_b=16'h0003, op_sel=00. start high exactly 1 cycle, then BUSY; calc_done -> RESULT, result_valid=1.
- Keys 9,8,7,6,5 -> operand_a=16'h9876, a_count=4, key_err pulse on '5' only.
- key_valid held 50 cycles with code 7 -> single digit appended. The register updates exactly 2 edges after first high sample.
- Keys 4,B,C,2 -> op_sel=10 (replacement). Then C again -> key_err, op_sel stays 10.
- calc_ready=0 for 10 cycles in LAUNCH -> start held 10+ cycles until ready. F pressed during BUSY -> key_err, state stays BUSY.
- rst asserted low while start=1 -> start, busy, operands drop to 0 immediately; after release, key 5 -> ENTER_A, operand_a=16'h0005.
